// File: rtl/fifo_status_pkg.sv
// Shared defaults for the fifo_status slice: word/address widths and the
// power-on threshold words the control FSM programs.
package fifo_status_pkg;

    localparam int DATA_W_DEF    = 6;
    localparam int ADDR_W_DEF    = 3;
    localparam int UMBRAL_AF_RST = 6;
    localparam int UMBRAL_AE_RST = 2;

    function automatic int depth_of(input int addr_w);
        return 1 << addr_w;
    endfunction

endpackage

// File: rtl/fifo_status_mem.sv
// DEPTH x DATA_W storage for fifo_status: one synchronous write port and one
// registered read port whose output register clears on reset.
module fifo_status_mem
    import fifo_status_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_data
);

    logic [DATA_W-1:0] mem [depth_of(ADDR_W)];

    // NOTE: the array has no reset; clearing it would turn the RAM into flops,
    // and the pointers already make stale entries unreachable.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // A same-cycle write to rd_addr lands after this read, so a full FIFO
    // doing read+write returns the oldest word, not the new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_data <= '0;
        end else if (rd_en) begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/fifo_status.sv
// Synchronous FIFO with programmable almost-full/almost-empty status flags.
// Define FIFO_ERR_STICKY_EN to hold fifo_error high until reset.
module fifo_status
    import fifo_status_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              rd_en,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    input  logic [ADDR_W-1:0] umbral_af,
    input  logic [ADDR_W-1:0] umbral_ae,
    output logic              fifo_empty,
    output logic              fifo_full,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              fifo_error
);

    localparam logic [ADDR_W:0] COUNT_FULL = (ADDR_W + 1)'(depth_of(ADDR_W));

    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic [ADDR_W:0]   count;
    logic              rd_acc;
    logic              wr_acc;
    logic              err_now;

    assign fifo_empty   = (count == '0);
    assign fifo_full    = (count == COUNT_FULL);
    assign almost_full  = (umbral_af != '0) && (count >= {1'b0, umbral_af});
    assign almost_empty = (count <= {1'b0, umbral_ae});

    // A full FIFO still takes a write when a read frees a slot the same cycle;
    // an empty FIFO never lets a write fall through to the read side.
    assign rd_acc  = rd_en && !fifo_empty;
    assign wr_acc  = wr_en && (!fifo_full || rd_acc);
    assign err_now = (wr_en && !wr_acc) || (rd_en && fifo_empty);

    fifo_status_mem #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (wr_acc),
        .wr_addr (wr_ptr),
        .wr_data (data_in),
        .rd_en   (rd_acc),
        .rd_addr (rd_ptr),
        .rd_data (data_out)
    );

    // NOTE: non-blocking assignments keep every register sampling the
    // pre-edge values, so the order of statements here does not matter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            valid_out  <= 1'b0;
            fifo_error <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            valid_out <= rd_acc;
`ifdef FIFO_ERR_STICKY_EN
            fifo_error <= fifo_error | err_now;
`else
            fifo_error <= err_now;
`endif
        end
    end

endmodule
